status_link_rx: RTL and testbench
=================================

// Module: status_link_rx
// PURPOSE
//  Remote-panel end of the alarm status link. Receives the serial status frame
//  driven on STATUS_OUT/STATUS_SEND by the main alarm module and deserializes it.
//  Validates framing and plausibility, then holds {armed, alarm, sensor1, sensor2}
//  for the panel LEDs and buzzer. Both ends run on the shared SERCLK_OUT clock.
// PARAMETERS
//  MSG_W        4    payload bits per frame (MSB first)
//  SB_MIN       3    minimum idle clocks between frames (stand-by gap)
//  LOSS_TIMEOUT 64   clocks without a good frame before LINK_LOST (watchdog only)
// PORTS
//  SERCLK_OUT      in   1  link clock; all state changes on its rising edge
//  RESET_IN        in   1  reset, asynchronous, active-high
//  STATUS_SEND     in   1  frame-start strobe, 1 clock wide
//  STATUS_OUT      in   1  serial payload bit
//  ARMED           out  1  held payload bit 3 (system not INACTIVO)
//  ALARM           out  1  held payload bit 2 (siren on)
//  SENSOR1         out  1  held payload bit 1 (window)
//  SENSOR2         out  1  held payload bit 0 (door)
//  FRAME_VALID     out  1  1-clock pulse: good frame accepted
//  STATUS_CHANGED  out  1  1-clock pulse, with FRAME_VALID, when held word changed
//  FRAME_ERR       out  1  1-clock pulse: frame discarded or gap violated
//  LINK_LOST       out  1  watchdog flag (0 when STATUS_LINK_WDOG_EN undefined)
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; shift reg, bit count, gap count cleared.
//  Frame: STATUS_SEND=1 sampled at edge t; payload bits sampled at t+1..t+MSG_W, MSB first.
//  FSM IDLE -> SHIFT on STATUS_SEND=1; STATUS_OUT at edge t ignored.
//  SHIFT: shift in 1 bit/clock; after bit MSG_W-1 -> GAP, clear gap count.
//  Held outputs, FRAME_VALID and STATUS_CHANGED update at edge t+MSG_W+1.
//  Latency: 1 clock after the last bit.
//  GAP: count idle clocks; at count SB_MIN -> IDLE.
//  STATUS_SEND=1 in GAP before SB_MIN: pulse FRAME_ERR.
//    Treat as a new frame start (-> SHIFT); the prior frame stays accepted.
//  STATUS_SEND=1 during SHIFT: abort the partial frame, pulse FRAME_ERR.
//    Restart SHIFT with bit count 0; held outputs unchanged.
//  Plausibility: ALARM=1 with ARMED=0 is illegal.
//    Frame discarded, FRAME_ERR pulses, FRAME_VALID stays 0, held outputs unchanged.
//  FRAME_VALID and FRAME_ERR are never high in the same clock.
//  STATUS_CHANGED=1 only if the accepted word != the previous held word.
//    First frame after reset compares against 4'b0000.
//  RESET_IN mid-frame: immediate async clear; partial frame lost, no pulses.
// CONFIGURATION
//  `STATUS_LINK_WDOG_EN defined: counter clears on each FRAME_VALID.
//    Counter increments otherwise and saturates at LOSS_TIMEOUT.
//    At LOSS_TIMEOUT, LINK_LOST=1 and ALARM is forced 1 (fail-safe buzzer).
//    Held word otherwise kept; the next FRAME_VALID clears LINK_LOST in the same edge.
//  Undefined: no counter, LINK_LOST tied 0, ALARM purely the held bit.
// STRUCTURE
//  Package status_link_pkg: FSM state enum {IDLE, SHIFT, GAP}.
//  It also holds the payload bit-index localparams (ARMED_B=3, ALARM_B=2, S1_B=1, S2_B=0)
//  and the default MSG_W/SB_MIN shared with the transmitter.
//  One sub-module: link_watchdog, a saturating counter with clear, used only under the macro.
// TESTING
//  1 Reset, frame 4'b1000, gap 3 -> ARMED=1 at edge t+5, FRAME_VALID and STATUS_CHANGED pulse.
//  2 Same 4'b1000 frame repeated -> FRAME_VALID pulses, STATUS_CHANGED stays 0.
//  3 Frame 4'b0100 -> FRAME_ERR pulse, outputs hold 4'b1000, FRAME_VALID 0.
//  4 STATUS_SEND after 2 payload bits, then full 4'b1101 -> FRAME_ERR at abort.
//    Then the outputs show 1101 with FRAME_VALID.
//  5 Frame 4'b1010, STATUS_SEND 1 clock into gap, frame 4'b1001 -> FRAME_ERR.
//    1010 was accepted, then 1001 is accepted.
//  6 WDOG_EN, LOSS_TIMEOUT=64, no frames for 64 clocks -> LINK_LOST=1, ALARM=1.
//    Next good frame 4'b1000 -> LINK_LOST=0, ALARM=0.

Source files
------------

// File: rtl/status_link_rx_pkg.sv
// status_link_pkg: shared types and constants for both ends of the status link. Rev 1.0
`default_nettype none

package status_link_pkg;

    localparam int MSG_W_DEF  = 4;
    localparam int SB_MIN_DEF = 3;

    localparam int ARMED_B = 3;
    localparam int ALARM_B = 2;
    localparam int S1_B    = 1;
    localparam int S2_B    = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_e;

    // A sounding siren on a disarmed system can only come from a corrupted frame
    function automatic logic is_plausible(input logic armed, input logic alarm);
        return !(alarm && !armed);
    endfunction

endpackage

`default_nettype wire

// File: rtl/status_link_rx_if.sv
// status_link_if: serial status link pins plus the panel-side decoded outputs. Rev 1.0
`default_nettype none

interface status_link_if;
    logic STATUS_SEND;
    logic STATUS_OUT;
    logic ARMED;
    logic ALARM;
    logic SENSOR1;
    logic SENSOR2;
    logic FRAME_VALID;
    logic STATUS_CHANGED;
    logic FRAME_ERR;
    logic LINK_LOST;

    modport master (
        output STATUS_SEND, STATUS_OUT,
        input  ARMED, ALARM, SENSOR1, SENSOR2,
        input  FRAME_VALID, STATUS_CHANGED, FRAME_ERR, LINK_LOST
    );

    modport slave (
        input  STATUS_SEND, STATUS_OUT,
        output ARMED, ALARM, SENSOR1, SENSOR2,
        output FRAME_VALID, STATUS_CHANGED, FRAME_ERR, LINK_LOST
    );
endinterface

`default_nettype wire

// File: rtl/status_link_rx_watchdog.sv
// link_watchdog: saturating clock counter with clear; flags saturation. Rev 1.0
`default_nettype none

module link_watchdog #(
    parameter int MAX = 64
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clr,
    output logic      sat
);

    localparam int W = $clog2(MAX + 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q != W'(MAX)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat = (cnt_q == W'(MAX));

endmodule

`default_nettype wire

// File: rtl/status_link_rx.sv
// status_link_rx: remote-panel deserializer/validator for the alarm status link. Rev 1.0
// Define STATUS_LINK_WDOG_EN to add the link-loss watchdog with fail-safe buzzer.
`default_nettype none

module status_link_rx
    import status_link_pkg::*;
#(
    parameter int MSG_W        = MSG_W_DEF,
    parameter int SB_MIN       = SB_MIN_DEF,
    parameter int LOSS_TIMEOUT = 64
) (
    input  wire logic    SERCLK_OUT,
    input  wire logic    RESET_IN,
    status_link_if.slave link
);

    localparam int CW = $clog2(MSG_W + 1);
    localparam int GW = $clog2(SB_MIN + 1);

    state_e           state_q, state_d;
    logic [MSG_W-1:0] shift_q, shift_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
    logic             done_q, done_d;
    logic [MSG_W-1:0] held_q, held_d;
    logic             valid_q, valid_d;
    logic             changed_q, changed_d;
    logic             err_q, err_d;
    logic             err_pend_q, err_pend_d;

    logic             last_bit;
    logic             abort;
    logic             gap_err;
    logic             plausible;
    logic             err_req;

    assign last_bit = (bit_cnt_q == CW'(MSG_W - 1));

    always_ff @(posedge SERCLK_OUT or posedge RESET_IN) begin
        if (RESET_IN) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            done_q     <= 1'b0;
            held_q     <= '0;
            valid_q    <= 1'b0;
            changed_q  <= 1'b0;
            err_q      <= 1'b0;
            err_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            done_q     <= done_d;
            held_q     <= held_d;
            valid_q    <= valid_d;
            changed_q  <= changed_d;
            err_q      <= err_d;
            err_pend_q <= err_pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (link.STATUS_SEND) state_d = SHIFT;
            end
            SHIFT: begin
                if (link.STATUS_SEND)  state_d = SHIFT;
                else if (last_bit)     state_d = GAP;
            end
            GAP: begin
                if (link.STATUS_SEND)                     state_d = SHIFT;
                else if (gap_cnt_q == GW'(SB_MIN - 1))    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        done_d    = 1'b0;
        abort     = 1'b0;
        gap_err   = 1'b0;
        case (state_q)
            IDLE: begin
                if (link.STATUS_SEND) bit_cnt_d = '0;
            end
            SHIFT: begin
                if (link.STATUS_SEND) begin
                    abort     = 1'b1;
                    bit_cnt_d = '0;
                end else begin
                    shift_d   = {shift_q[MSG_W-2:0], link.STATUS_OUT};
                    bit_cnt_d = bit_cnt_q + CW'(1);
                    if (last_bit) begin
                        done_d    = 1'b1;
                        gap_cnt_d = '0;
                    end
                end
            end
            GAP: begin
                if (link.STATUS_SEND) begin
                    gap_err   = 1'b1;
                    bit_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            default: ;
        endcase

        // The completed word is judged one clock after its last bit
        plausible = is_plausible(shift_q[ARMED_B], shift_q[ALARM_B]);
        valid_d   = done_q && plausible;
        held_d    = valid_d ? shift_q : held_q;
        changed_d = valid_d && (shift_q != held_q);

        // An early start landing on the acceptance clock is reported one clock later,
        // so FRAME_VALID and FRAME_ERR never overlap
        err_req    = abort || gap_err || (done_q && !plausible) || err_pend_q;
        err_d      = err_req && !valid_d;
        err_pend_d = err_req && valid_d;
    end

    assign link.ARMED          = held_q[ARMED_B];
    assign link.SENSOR1        = held_q[S1_B];
    assign link.SENSOR2        = held_q[S2_B];
    assign link.FRAME_VALID    = valid_q;
    assign link.STATUS_CHANGED = changed_q;
    assign link.FRAME_ERR      = err_q;

`ifdef STATUS_LINK_WDOG_EN
    logic link_lost;

    link_watchdog #(
        .MAX (LOSS_TIMEOUT)
    ) u_link_watchdog (
        .clk (SERCLK_OUT),
        .rst (RESET_IN),
        .clr (valid_d),
        .sat (link_lost)
    );

    assign link.LINK_LOST = link_lost;
    assign link.ALARM     = held_q[ALARM_B] | link_lost;
`else
    assign link.LINK_LOST = 1'b0;
    assign link.ALARM     = held_q[ALARM_B];
`endif

endmodule

`default_nettype wire

// File: tb/tb_status_link_rx.sv
// tb_status_link_rx: table, directed and random checks of status_link_rx against a timeline model. Rev 1.0
`default_nettype none

module tb_status_link_rx;

    localparam int MSG_W        = 4;
    localparam int SB_MIN       = 3;
    localparam int LOSS_TIMEOUT = 64;
`ifdef STATUS_LINK_WDOG_EN
    localparam bit WDOG = 1'b1;
`else
    localparam bit WDOG = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    status_link_if lnk ();

    status_link_rx #(
        .MSG_W        (MSG_W),
        .SB_MIN       (SB_MIN),
        .LOSS_TIMEOUT (LOSS_TIMEOUT)
    ) dut (
        .SERCLK_OUT (clk),
        .RESET_IN   (rst),
        .link       (lnk)
    );

    int nvec = 0;
    int nerr = 0;

    // Timeline model: frames are tracked by the edge they started on
    int       m_n;
    bit       m_active;
    int       m_start;
    bit       m_gapping;
    int       m_comp;
    logic [3:0] m_acc;
    bit       m_eval;
    logic [3:0] m_eval_word;
    bit       m_defer;
    logic [3:0] m_held;
    int       m_wd;
    bit       e_valid, e_chg, e_err;

    task automatic model_reset();
        m_n = 0; m_active = 0; m_start = 0; m_gapping = 0; m_comp = 0;
        m_acc = '0; m_eval = 0; m_eval_word = '0; m_defer = 0;
        m_held = '0; m_wd = 0; e_valid = 0; e_chg = 0; e_err = 0;
    endtask

    task automatic model_step(input bit send, input bit sd);
        bit err;
        m_n++;
        e_valid = 0; e_chg = 0; err = 0;
        if (m_eval) begin
            if (m_eval_word[2] && !m_eval_word[3]) begin
                err = 1;
            end else begin
                e_valid = 1;
                e_chg   = (m_eval_word != m_held);
                m_held  = m_eval_word;
            end
            m_eval = 0;
        end
        if (m_defer) begin
            err = 1;
            m_defer = 0;
        end
        if (send) begin
            if (m_active || (m_gapping && (m_n - m_comp) <= SB_MIN)) err = 1;
            m_active = 1; m_start = m_n; m_acc = '0; m_gapping = 0;
        end else if (m_active) begin
            m_acc = {m_acc[2:0], sd};
            if (m_n - m_start == MSG_W) begin
                m_active = 0; m_eval = 1; m_eval_word = m_acc;
                m_gapping = 1; m_comp = m_n;
            end
        end
        if (e_valid && err) begin
            m_defer = 1;
            err = 0;
        end
        e_err = err;
        if (e_valid) m_wd = 0;
        else if (m_wd < LOSS_TIMEOUT) m_wd++;
    endtask

    function automatic logic [7:0] model_out();
        bit lost;
        lost = WDOG && (m_wd == LOSS_TIMEOUT);
        return {m_held[3], m_held[2] | lost, m_held[1], m_held[0], e_valid, e_chg, e_err, lost};
    endfunction

    function automatic logic [7:0] dut_out();
        return {lnk.ARMED, lnk.ALARM, lnk.SENSOR1, lnk.SENSOR2,
                lnk.FRAME_VALID, lnk.STATUS_CHANGED, lnk.FRAME_ERR, lnk.LINK_LOST};
    endfunction

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %b expected %b (arm,alm,s1,s2,valid,chg,err,lost)", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic apply(input bit send, input bit sd);
        lnk.STATUS_SEND = send;
        lnk.STATUS_OUT  = sd;
        @(posedge clk);
        #1;
        model_step(send, sd);
        check8("model", dut_out(), model_out());
    endtask

    task automatic do_reset();
        rst = 1'b1;
        lnk.STATUS_SEND = 1'b0;
        lnk.STATUS_OUT  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit         send;
        bit         sd;
        bit         valid;
        bit         chg;
        bit         err;
        logic [3:0] held;
    } vec_t;

    vec_t tbl[24];

    function automatic vec_t mk(bit send, bit sd, bit valid, bit chg, bit err, logic [3:0] held);
        vec_t v;
        v.send = send; v.sd = sd; v.valid = valid; v.chg = chg; v.err = err; v.held = held;
        return v;
    endfunction

    initial begin
        // Frame 1000, repeat 1000, then implausible 0100
        tbl[0]  = mk(1, 0, 0, 0, 0, 4'b0000);
        tbl[1]  = mk(0, 1, 0, 0, 0, 4'b0000);
        tbl[2]  = mk(0, 0, 0, 0, 0, 4'b0000);
        tbl[3]  = mk(0, 0, 0, 0, 0, 4'b0000);
        tbl[4]  = mk(0, 0, 0, 0, 0, 4'b0000);
        tbl[5]  = mk(0, 0, 1, 1, 0, 4'b1000);
        tbl[6]  = mk(0, 0, 0, 0, 0, 4'b1000);
        tbl[7]  = mk(0, 0, 0, 0, 0, 4'b1000);
        tbl[8]  = mk(1, 0, 0, 0, 0, 4'b1000);
        tbl[9]  = mk(0, 1, 0, 0, 0, 4'b1000);
        tbl[10] = mk(0, 0, 0, 0, 0, 4'b1000);
        tbl[11] = mk(0, 0, 0, 0, 0, 4'b1000);
        tbl[12] = mk(0, 0, 0, 0, 0, 4'b1000);
        tbl[13] = mk(0, 0, 1, 0, 0, 4'b1000);
        tbl[14] = mk(0, 0, 0, 0, 0, 4'b1000);
        tbl[15] = mk(0, 0, 0, 0, 0, 4'b1000);
        tbl[16] = mk(1, 0, 0, 0, 0, 4'b1000);
        tbl[17] = mk(0, 0, 0, 0, 0, 4'b1000);
        tbl[18] = mk(0, 1, 0, 0, 0, 4'b1000);
        tbl[19] = mk(0, 0, 0, 0, 0, 4'b1000);
        tbl[20] = mk(0, 0, 0, 0, 0, 4'b1000);
        tbl[21] = mk(0, 0, 0, 0, 1, 4'b1000);
        tbl[22] = mk(0, 0, 0, 0, 0, 4'b1000);
        tbl[23] = mk(0, 0, 0, 0, 0, 4'b1000);

        model_reset();
        do_reset();
        check8("reset_state", dut_out(), 8'b0000_0000);

        for (int i = 0; i < 24; i++) begin
            apply(tbl[i].send, tbl[i].sd);
            check8($sformatf("tbl[%0d]", i), dut_out(),
                   {tbl[i].held[3], tbl[i].held[2], tbl[i].held[1], tbl[i].held[0],
                    tbl[i].valid, tbl[i].chg, tbl[i].err, 1'b0});
        end

        // Abort after two payload bits, then a full 1101
        apply(1, 0); apply(0, 1); apply(0, 1);
        apply(1, 0);
        check1("abort_err", lnk.FRAME_ERR, 1'b1);
        check8("abort_hold", {dut_out()[7:4], 4'b0000}, 8'b1000_0000);
        apply(0, 1); apply(0, 1); apply(0, 0); apply(0, 1);
        apply(0, 0);
        check8("after_abort", dut_out(), 8'b1101_1100);
        apply(0, 0); apply(0, 0);

        // Early start one clock into the gap
        apply(1, 0); apply(0, 1); apply(0, 0); apply(0, 1); apply(0, 0);
        apply(1, 0);
        check8("gap_accept_1010", dut_out(), 8'b1010_1100);
        apply(0, 1);
        check1("gap_err", lnk.FRAME_ERR, 1'b1);
        check1("gap_err_no_valid", lnk.FRAME_VALID, 1'b0);
        apply(0, 0); apply(0, 0); apply(0, 1);
        apply(0, 0);
        check8("accept_1001", dut_out(), 8'b1001_1100);
        apply(0, 0); apply(0, 0);

        // Asynchronous reset in the middle of a frame
        apply(1, 0); apply(0, 1); apply(0, 1);
        #2 rst = 1'b1;
        #1 check8("async_reset", dut_out(), 8'b0000_0000);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) apply(0, 1);
        check8("post_reset_quiet", dut_out(), 8'b0000_0000);

        // Watchdog behaviour from a fresh reset
        do_reset();
        for (int i = 0; i < LOSS_TIMEOUT - 1; i++) apply(0, 0);
        check1("wdog_not_yet", lnk.LINK_LOST, 1'b0);
        apply(0, 0);
        check1("wdog_lost", lnk.LINK_LOST, WDOG);
        check1("wdog_alarm", lnk.ALARM, WDOG);
        for (int i = 0; i < 6; i++) apply(0, 0);
        check1("lost_held", lnk.LINK_LOST, WDOG);
        apply(1, 0); apply(0, 1); apply(0, 0); apply(0, 0); apply(0, 0);
        apply(0, 0);
        check8("wdog_recover", dut_out(), 8'b1000_1100);
        apply(0, 0); apply(0, 0);

        // Random traffic against the model
        for (int i = 0; i < 800; i++) begin
            apply($urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

`default_nettype wire
